// File: rtl/vec_act_fp16_ingress.sv
// ----------------------------------------------------------------------------
// vec_act_fp16_ingress
//
// Streaming ingress stage for the vec_act_fp16_* activation lanes. Each
// accepted IEEE binary16 element is classified into the lanes' 18-bit tagged
// format {tag[1:0], sign, exp[4:0], mant[9:0]}. The element travels with the
// opcode of its vector, its index and a last flag. A primary output register
// plus one skid entry absorbs downstream backpressure without a combinational
// ready path.
//
// Tags: 01 = number (normal or zero, subnormals flushed to signed zero),
//       10 = infinity, 11 = NaN.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream element valid
//   in_ready   stage can accept an element (registered, "skid entry empty")
//   in_data    IEEE binary16 element
//   in_op      activation opcode, latched on the first element of a vector
//   out_valid  downstream element valid
//   out_ready  downstream accepts
//   out_data   tagged fp16 element
//   out_op     opcode of the vector owning this element
//   out_idx    element index within the vector, 0..VEC_LEN-1
//   out_last   high on the final element of a vector
//   stats_clr  synchronous clear of flush_cnt / nan_seen / op_err
//   flush_cnt  saturating count of subnormal inputs flushed to zero
//   nan_seen   sticky: a NaN input was accepted
//   op_err     sticky: in_op changed mid-vector
// ----------------------------------------------------------------------------
module vec_act_fp16_ingress #(
    parameter int VEC_LEN = 16,
    parameter int IDX_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [17:0]      out_data,
    output logic [2:0]       out_op,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    input  logic             stats_clr,
    output logic [15:0]      flush_cnt,
    output logic             nan_seen,
    output logic             op_err
);

    localparam logic [1:0]       TAG_NUM  = 2'b01;
    localparam logic [1:0]       TAG_INF  = 2'b10;
    localparam logic [1:0]       TAG_NAN  = 2'b11;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

    // One element as it sits in the output register or the skid entry.
    typedef struct packed {
        logic [17:0]      data;
        logic [2:0]       op;
        logic [IDX_W-1:0] idx;
        logic             last;
    } elem_t;

    elem_t            out_q, out_d;
    elem_t            skid_q, skid_d;
    elem_t            new_elem;
    logic             skid_valid, skid_valid_d;
    logic             out_valid_d;
    logic [IDX_W-1:0] idx_q;
    logic [2:0]       op_q;

    logic [4:0]       exp_f;
    logic [9:0]       mant_f;
    logic             is_sub;
    logic             is_nan;
    logic [17:0]      cls_data;
    logic             accept;
    logic             out_free;

    assign accept   = in_valid && in_ready;
    // The output register can take a new value when empty or being emitted.
    assign out_free = !out_valid || out_ready;

    // ------------------------------------------------------------------
    // Classification of the incoming element
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        exp_f    = in_data[14:10];
        mant_f   = in_data[9:0];
        is_sub   = 1'b0;
        is_nan   = 1'b0;
        cls_data = {TAG_NUM, in_data};
        if (exp_f == 5'h1f) begin
            if (mant_f == 10'd0) begin
                cls_data = {TAG_INF, in_data};
            end else begin
                cls_data = {TAG_NAN, in_data};
                is_nan   = 1'b1;
            end
        end else if (exp_f == 5'd0 && mant_f != 10'd0) begin
            // Subnormal: flush to zero but keep the sign.
            cls_data = {TAG_NUM, in_data[15], 15'd0};
            is_sub   = 1'b1;
        end
    end

    // The first element of a vector carries its own in_op; later elements
    // use the opcode latched from that first element.
    always_comb begin
        new_elem.data = cls_data;
        new_elem.op   = (idx_q == '0) ? in_op : op_q;
        new_elem.idx  = idx_q;
        new_elem.last = (idx_q == LAST_IDX);
    end

    // ------------------------------------------------------------------
    // Output register + skid entry, next-state
    // ------------------------------------------------------------------
    // An accept only happens with the skid entry empty (in_ready mirrors
    // it), so the skid entry never has to hold two things at once.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid;
        skid_d       = skid_q;
        skid_valid_d = skid_valid;
        if (out_free) begin
            if (skid_valid) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = new_elem;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = new_elem;
            skid_valid_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    // NOTE: the data registers are reset too; the block is small and all
    // outputs must read 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            out_valid  <= 1'b0;
            skid_q     <= '0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b0;
        end else begin
            out_q      <= out_d;
            out_valid  <= out_valid_d;
            skid_q     <= skid_d;
            skid_valid <= skid_valid_d;
            // Registered from next-state skid occupancy: no path from
            // out_ready to in_ready within a cycle.
            in_ready   <= !skid_valid_d;
        end
    end

    assign out_data = out_q.data;
    assign out_op   = out_q.op;
    assign out_idx  = out_q.idx;
    assign out_last = out_q.last;

    // ------------------------------------------------------------------
    // Element index and per-vector opcode
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            op_q  <= 3'd0;
        end else if (accept) begin
            if (idx_q == '0) begin
                op_q <= in_op;
            end
            idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sticky statistics, counted at accept; clear wins over a same-cycle
    // update.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            flush_cnt <= 16'd0;
            nan_seen  <= 1'b0;
            op_err    <= 1'b0;
        end else if (accept) begin
            if (is_sub && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
            if (is_nan) begin
                nan_seen <= 1'b1;
            end
            if (idx_q != '0 && in_op != op_q) begin
                op_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vec_act_fp16_ingress.sv
// ----------------------------------------------------------------------------
// Self-checking bench for vec_act_fp16_ingress (instantiated with VEC_LEN=4).
// Directed tables cover classification and opcode latching; hand-written
// sequences cover backpressure and reset with a full skid entry; a random
// valid/ready phase is checked against a scoreboard model.
// ----------------------------------------------------------------------------
module tb_vec_act_fp16_ingress;

    localparam int VL = 4;
    localparam int IW = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_data;
    logic [2:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [17:0]   out_data;
    logic [2:0]    out_op;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          stats_clr;
    logic [15:0]   flush_cnt;
    logic          nan_seen;
    logic          op_err;

    vec_act_fp16_ingress #(.VEC_LEN(VL), .IDX_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_op    (out_op),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .stats_clr (stats_clr),
        .flush_cnt (flush_cnt),
        .nan_seen  (nan_seen),
        .op_err    (op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [2:0]  op;
        logic [17:0] ed;
        logic [2:0]  eop;
        logic        eerr;
    } vec_t;

    typedef struct packed {
        logic [17:0]   data;
        logic [2:0]    op;
        logic [IW-1:0] idx;
        logic          last;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_acc = 0;
    exp_t sbq[$];
    int   m_idx;
    logic [2:0]  m_op;
    logic [15:0] m_flush;
    logic        m_nan;
    logic        m_operr;

    vec_t ta[14];
    vec_t tv[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [15:0] d, input logic [2:0] op,
                                input logic [17:0] ed, input logic [2:0] eop,
                                input logic eerr);
        vec_t v;
        v.d = d; v.op = op; v.ed = ed; v.eop = eop; v.eerr = eerr;
        return v;
    endfunction

    // Reference classification into the tagged format.
    function automatic logic [17:0] ref_cls(input logic [15:0] d);
        if (d[14:10] == 5'h1f) return (d[9:0] == 0) ? {2'b10, d} : {2'b11, d};
        if (d[14:10] == 5'h00 && d[9:0] != 0) return {2'b01, d[15], 15'd0};
        return {2'b01, d};
    endfunction

    task automatic model_reset();
        sbq.delete();
        m_idx = 0; m_op = 3'd0; m_flush = 16'd0; m_nan = 1'b0; m_operr = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; stats_clr = 1'b0;
        in_data = 16'd0; in_op = 3'd0;
        step();
        rst = 1'b0;
        step();
        model_reset();
    endtask

    // One clock of scoreboarded traffic: predicts accept/emit from the
    // pre-edge handshake, then checks occupancy-derived in_ready/out_valid.
    task automatic cycle(input logic v, input logic [15:0] d, input logic [2:0] op, input logic rdy);
        logic acc, emt;
        exp_t e;
        in_valid = v; in_data = d; in_op = op; out_ready = rdy;
        acc = v && in_ready;
        emt = out_valid && rdy;
        if (emt) begin
            if (sbq.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("sb_data", out_data, e.data);
                check("sb_op",   out_op,   e.op);
                check("sb_idx",  out_idx,  e.idx);
                check("sb_last", out_last, e.last);
            end
        end
        if (acc) begin
            if (m_idx == 0) m_op = op;
            else if (op != m_op) m_operr = 1'b1;
            if (d[14:10] == 0 && d[9:0] != 0 && m_flush != 16'hFFFF) m_flush++;
            if (d[14:10] == 5'h1f && d[9:0] != 0) m_nan = 1'b1;
            e.data = ref_cls(d); e.op = m_op; e.idx = IW'(m_idx); e.last = (m_idx == VL - 1);
            sbq.push_back(e);
            m_idx = (m_idx + 1) % VL;
            n_acc++;
        end
        step();
        check("inv_ready", in_ready, sbq.size() < 2);
        check("inv_valid", out_valid, sbq.size() != 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Classification table: index runs 0..3 repeatedly with VL=4.
        ta[0]  = mk(16'h3C00, 3'd0, 18'h13C00, 3'd0, 1'b0);
        ta[1]  = mk(16'hBC00, 3'd0, 18'h1BC00, 3'd0, 1'b0);
        ta[2]  = mk(16'h0000, 3'd0, 18'h10000, 3'd0, 1'b0);
        ta[3]  = mk(16'h3800, 3'd0, 18'h13800, 3'd0, 1'b0);
        ta[4]  = mk(16'h7C00, 3'd0, 18'h27C00, 3'd0, 1'b0);
        ta[5]  = mk(16'hFC00, 3'd0, 18'h2FC00, 3'd0, 1'b0);
        ta[6]  = mk(16'h7E00, 3'd0, 18'h37E00, 3'd0, 1'b0);
        ta[7]  = mk(16'h0001, 3'd0, 18'h10000, 3'd0, 1'b0);
        ta[8]  = mk(16'h8001, 3'd0, 18'h18000, 3'd0, 1'b0);
        ta[9]  = mk(16'h7BFF, 3'd0, 18'h17BFF, 3'd0, 1'b0);
        ta[10] = mk(16'h0400, 3'd0, 18'h10400, 3'd0, 1'b0);
        ta[11] = mk(16'h83FF, 3'd0, 18'h18000, 3'd0, 1'b0);
        ta[12] = mk(16'hFFFF, 3'd0, 18'h3FFFF, 3'd0, 1'b0);
        ta[13] = mk(16'h8000, 3'd0, 18'h18000, 3'd0, 1'b0);
        // Opcode table: op 5 latched for vector 0, op 2 for vectors 1 and 2.
        tv[0] = mk(16'h3C00, 3'd5, 18'h13C00, 3'd5, 1'b0);
        tv[1] = mk(16'h3C01, 3'd2, 18'h13C01, 3'd5, 1'b1);
        tv[2] = mk(16'h3C02, 3'd5, 18'h13C02, 3'd5, 1'b1);
        tv[3] = mk(16'h3C03, 3'd5, 18'h13C03, 3'd5, 1'b1);
        tv[4] = mk(16'h3C04, 3'd2, 18'h13C04, 3'd2, 1'b1);
        tv[5] = mk(16'h3C05, 3'd2, 18'h13C05, 3'd2, 1'b1);
        tv[6] = mk(16'h3C06, 3'd2, 18'h13C06, 3'd2, 1'b1);
        tv[7] = mk(16'h3C07, 3'd2, 18'h13C07, 3'd2, 1'b1);
        tv[8] = mk(16'h3C08, 3'd2, 18'h13C08, 3'd2, 1'b1);

        // ---- reset state ----
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; stats_clr = 1'b0;
        in_data = 16'd0; in_op = 3'd0;
        step();
        step();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready",  in_ready,  1'b0);
        check("rst_out_data",  out_data,  18'd0);
        check("rst_flush",     flush_cnt, 16'd0);
        check("rst_nan",       nan_seen,  1'b0);
        check("rst_op_err",    op_err,    1'b0);
        rst = 1'b0;
        step();
        check("post_rst_ready", in_ready, 1'b1);

        // ---- classification, back-to-back, 1-cycle latency ----
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1; in_data = ta[i].d; in_op = ta[i].op; out_ready = 1'b1;
            step();
            check("ta_valid", out_valid, 1'b1);
            check("ta_ready", in_ready,  1'b1);
            check("ta_data",  out_data,  ta[i].ed);
            check("ta_op",    out_op,    ta[i].eop);
            check("ta_idx",   out_idx,   i % VL);
            check("ta_last",  out_last,  (i % VL) == VL - 1);
            check("ta_err",   op_err,    ta[i].eerr);
        end
        in_valid = 1'b0;
        step();
        check("ta_drained", out_valid, 1'b0);
        check("ta_flush",   flush_cnt, 16'd3);
        check("ta_nan",     nan_seen,  1'b1);

        // stats_clr wins over a same-cycle subnormal accept
        stats_clr = 1'b1; in_valid = 1'b1; in_data = 16'h0001;
        step();
        check("clr_flush", flush_cnt, 16'd0);
        check("clr_nan",   nan_seen,  1'b0);
        stats_clr = 1'b0; in_data = 16'h7C01;
        step();
        check("clr_nan_set",  nan_seen,  1'b1);
        check("clr_flush_hold", flush_cnt, 16'd0);
        in_data = 16'h8002;
        step();
        check("clr_flush_inc", flush_cnt, 16'd1);
        in_valid = 1'b0;
        step();

        // ---- opcode latching across vectors ----
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_data = tv[i].d; in_op = tv[i].op; out_ready = 1'b1;
            step();
            check("tv_data", out_data, tv[i].ed);
            check("tv_op",   out_op,   tv[i].eop);
            check("tv_idx",  out_idx,  i % VL);
            check("tv_last", out_last, (i % VL) == VL - 1);
            check("tv_err",  op_err,   tv[i].eerr);
        end
        in_valid = 1'b0; stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        check("tv_err_clr", op_err, 1'b0);

        // ---- backpressure: stall 3 cycles mid-burst ----
        reset_dut();
        cycle(1'b1, 16'h3C00, 3'd1, 1'b1);
        check("bp_ready0", in_ready, 1'b1);
        cycle(1'b1, 16'h3C01, 3'd1, 1'b1);
        check("bp_ready1", in_ready, 1'b1);
        cycle(1'b1, 16'h3C02, 3'd1, 1'b0);
        check("bp_drop", in_ready, 1'b0);
        check("bp_hold0", out_data, 18'h13C01);
        cycle(1'b1, 16'h3C03, 3'd1, 1'b0);
        check("bp_hold1", out_data, 18'h13C01);
        check("bp_hold1_idx", out_idx, 1);
        cycle(1'b1, 16'h3C03, 3'd1, 1'b0);
        check("bp_hold2", out_data, 18'h13C01);
        cycle(1'b1, 16'h3C03, 3'd1, 1'b1);
        check("bp_rise", in_ready, 1'b1);
        check("bp_skid_out", out_data, 18'h13C02);
        cycle(1'b1, 16'h3C03, 3'd1, 1'b1);
        cycle(1'b1, 16'h3C04, 3'd1, 1'b1);
        cycle(1'b1, 16'h3C05, 3'd1, 1'b1);
        cycle(1'b0, 16'h0000, 3'd1, 1'b1);
        cycle(1'b0, 16'h0000, 3'd1, 1'b1);
        check("bp_count", n_acc, 6);

        // ---- reset with skid full ----
        reset_dut();
        cycle(1'b1, 16'h0001, 3'd0, 1'b0);
        cycle(1'b1, 16'h3C00, 3'd0, 1'b0);
        check("rf_full_ready", in_ready,  1'b0);
        check("rf_full_flush", flush_cnt, 16'd1);
        rst = 1'b1; in_valid = 1'b0;
        step();
        check("rf_valid", out_valid, 1'b0);
        check("rf_ready", in_ready,  1'b0);
        check("rf_flush", flush_cnt, 16'd0);
        model_reset();
        rst = 1'b0; in_valid = 1'b1; in_data = 16'h4000; out_ready = 1'b1;
        step();
        check("rf_ready_back", in_ready,  1'b1);
        check("rf_no_ghost",   out_valid, 1'b0);
        cycle(1'b1, 16'h4000, 3'd3, 1'b1);
        check("rf_first_data", out_data, 18'h14000);
        check("rf_first_idx",  out_idx,  0);
        check("rf_first_op",   out_op,   3'd3);
        cycle(1'b0, 16'h0000, 3'd0, 1'b1);

        // ---- random valid/ready over 1000 elements ----
        reset_dut();
        n_acc = 0;
        for (int c = 0; c < 20000 && n_acc < 1000; c++) begin
            logic [15:0] d;
            logic [2:0]  op;
            int sel;
            sel = $urandom_range(0, 7);
            d = 16'($urandom);
            case (sel)
                0: d[14:10] = 5'd0;
                1: d[14:10] = 5'h1f;
                2: d[14:0]  = 15'd0;
                default: ;
            endcase
            if (m_idx == 0 || $urandom_range(0, 9) == 0) op = 3'($urandom_range(0, 7));
            else op = m_op;
            cycle($urandom_range(0, 3) != 0, d, op, $urandom_range(0, 2) != 0);
        end
        check("rnd_count", n_acc, 1000);
        for (int c = 0; c < 10 && sbq.size() != 0; c++) begin
            cycle(1'b0, 16'h0000, 3'd0, 1'b1);
        end
        check("rnd_drain", sbq.size(), 0);
        check("rnd_flush", flush_cnt, m_flush);
        check("rnd_nan",   nan_seen,  m_nan);
        check("rnd_operr", op_err,    m_operr);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
